// File: rtl/alu_muldiv_if.sv
// Pipeline-side bundle for the iterative RV32M/RV64M multiply/divide unit:
// operand handshake, result handshake, flush and busy status.
interface alu_muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            flush;
    logic            inValid;
    logic            inReady;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [2:0]      mdOp;
    logic            outValid;
    logic            outReady;
    logic [XLEN-1:0] mdOut;
    logic            busy;

    modport master (
        output flush, inValid, opA, opB, mdOp, outReady,
        input  inReady, outValid, mdOut, busy
    );

    modport slave (
        input  flush, inValid, opA, opB, mdOp, outReady,
        output inReady, outValid, mdOut, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide: one shift-add or restoring-divide step per clock.
// Define ALU_MULDIV_EARLY_OUT_EN to let zero-operand, divide-by-zero and overflow cases skip BUSY.
module alu_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_muldiv_if.slave  bus
);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [2*XLEN-1:0]   acc_reg, acc_next;
    logic [XLEN-1:0]     mag_reg, mag_next;
    logic [XLEN-1:0]     opa_reg, opa_next;
    logic [2:0]          op_reg, op_next;
    logic                res_neg_reg, res_neg_next;
    logic                div_zero_reg, div_zero_next;
    logic                ovf_reg, ovf_next;
    logic [XLEN-1:0]     md_out_reg, md_out_next;
    logic                out_valid_reg, out_valid_next;

    // Operand decode at the input handshake
    logic            in_ready;
    logic            in_fire;
    logic            in_is_div;
    logic            signed_a;
    logic            signed_b;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            start_div_zero;
    logic            start_ovf;

    always_comb begin
        in_ready       = rst_n && (state_reg == S_IDLE);
        in_fire        = bus.inValid && in_ready;
        in_is_div      = bus.mdOp[2];
        signed_a       = (bus.mdOp == OP_MULH) || (bus.mdOp == OP_MULHSU) ||
                         (bus.mdOp == OP_DIV)  || (bus.mdOp == OP_REM);
        signed_b       = (bus.mdOp == OP_MULH) || (bus.mdOp == OP_DIV) || (bus.mdOp == OP_REM);
        neg_a          = signed_a && bus.opA[XLEN-1];
        neg_b          = signed_b && bus.opB[XLEN-1];
        mag_a          = neg_a ? (~bus.opA + XLEN'(1)) : bus.opA;
        mag_b          = neg_b ? (~bus.opB + XLEN'(1)) : bus.opB;
        start_div_zero = in_is_div && (bus.opB == '0);
        start_ovf      = ((bus.mdOp == OP_DIV) || (bus.mdOp == OP_REM)) &&
                         (bus.opA == MIN_NEG) && (bus.opB == '1);
    end

`ifdef ALU_MULDIV_EARLY_OUT_EN
    logic            early_hit;
    logic [XLEN-1:0] early_res;

    // Every bypassed case has a result computable straight from the raw operands.
    always_comb begin
        early_hit = (bus.opA == '0) || (bus.opB == '0) || start_ovf;
        early_res = '0;
        if (in_is_div) begin
            if (start_div_zero) begin
                early_res = bus.mdOp[1] ? bus.opA : '1;
            end else if (start_ovf) begin
                early_res = bus.mdOp[1] ? '0 : bus.opA;
            end
        end
    end
`endif

    // One iteration of the datapath, shared by multiply and divide
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     rem_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] div_step;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mag_reg} : '0);
        mul_step  = {mul_sum, acc_reg[XLEN-1:1]};
        rem_shift = acc_reg[2*XLEN-1:XLEN-1];
        div_ge    = rem_shift >= {1'b0, mag_reg};
        div_sub   = rem_shift[XLEN-1:0] - mag_reg;
        div_step  = div_ge ? {div_sub, acc_reg[XLEN-2:0], 1'b1}
                           : {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
        acc_step  = op_reg[2] ? div_step : mul_step;
    end

    // Sign correction and result selection from the final iteration
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_fix = res_neg_reg ? (~acc_step + (2*XLEN)'(1)) : acc_step;
        quo_fix  = res_neg_reg ? (~acc_step[XLEN-1:0] + XLEN'(1)) : acc_step[XLEN-1:0];
        rem_fix  = res_neg_reg ? (~acc_step[2*XLEN-1:XLEN] + XLEN'(1)) : acc_step[2*XLEN-1:XLEN];
        final_res = '0;
        case (op_reg[2:1])
            2'b00:   final_res = (op_reg[0] == 1'b0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            2'b01:   final_res = prod_fix[2*XLEN-1:XLEN];
            2'b10: begin
                if (div_zero_reg)  final_res = '1;
                else if (ovf_reg)  final_res = opa_reg;
                else               final_res = quo_fix;
            end
            default: begin
                if (div_zero_reg)  final_res = opa_reg;
                else if (ovf_reg)  final_res = '0;
                else               final_res = rem_fix;
            end
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        acc_next       = acc_reg;
        mag_next       = mag_reg;
        opa_next       = opa_reg;
        op_next        = op_reg;
        res_neg_next   = res_neg_reg;
        div_zero_next  = div_zero_reg;
        ovf_next       = ovf_reg;
        md_out_next    = md_out_reg;
        out_valid_next = out_valid_reg;

        case (state_reg)
            S_IDLE: begin
                if (in_fire) begin
                    op_next       = bus.mdOp;
                    opa_next      = bus.opA;
                    acc_next      = in_is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                    mag_next      = in_is_div ? mag_b : mag_a;
                    res_neg_next  = (bus.mdOp == OP_REM) ? neg_a : (neg_a ^ neg_b);
                    div_zero_next = start_div_zero;
                    ovf_next      = start_ovf;
                    cnt_next      = CNT_W'(XLEN);
                    state_next    = S_BUSY;
`ifdef ALU_MULDIV_EARLY_OUT_EN
                    if (early_hit) begin
                        md_out_next    = early_res;
                        out_valid_next = 1'b1;
                        state_next     = S_DONE;
                    end
`endif
                end
            end
            S_BUSY: begin
                acc_next = acc_step;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    md_out_next    = final_res;
                    out_valid_next = 1'b1;
                    state_next     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_valid_reg && bus.outReady) begin
                    out_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next     = S_IDLE;
                out_valid_next = 1'b0;
            end
        endcase

        // Flush wins over everything, including a handshake in the same cycle.
        if (bus.flush) begin
            state_next     = S_IDLE;
            cnt_next       = '0;
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            mag_reg       <= '0;
            opa_reg       <= '0;
            op_reg        <= '0;
            res_neg_reg   <= 1'b0;
            div_zero_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
            md_out_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            mag_reg       <= mag_next;
            opa_reg       <= opa_next;
            op_reg        <= op_next;
            res_neg_reg   <= res_neg_next;
            div_zero_reg  <= div_zero_next;
            ovf_reg       <= ovf_next;
            md_out_reg    <= md_out_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.inReady  = in_ready;
    assign bus.outValid = out_valid_reg;
    assign bus.mdOut    = md_out_reg;
    assign bus.busy     = (state_reg != S_IDLE);
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle integer ALU in the execute stage and takes the same opA/opB operands.
- Multi-cycle: one shift-add or restoring-divide step per clock, with valid/ready handshakes on both input and output so the pipeline can stall around it.

Parameters:
- XLEN, 32, operand/result width in bits; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  abort any in-flight operation; synchronous.
- inValid  in  1  operands and opcode valid.
- inReady  out  1  unit can accept an operation.
- opA  in  XLEN  rs1 value (multiplicand/dividend).
- opB  in  XLEN  rs2 value (multiplier/divisor).
- mdOp  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- outValid  out  1  mdOut holds a result.
- outReady  in  1  consumer accepts the result.
- mdOut  out  XLEN  registered result.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Clock, reset, outputs:
  - Single clock domain.
  - Reset is synchronous: rst_n low at a rising edge forces state=IDLE, counter=0, outValid=0, mdOut=0, and clears internal accumulators and sign flags.
  - inReady=0 while rst_n is low.
  - busy=0 after reset.
- State machine, IDLE:
  - inReady=1.
  - On inValid&&inReady: latch operand magnitudes, result-sign flag, opcode and special-case flags; counter=XLEN; go to BUSY.
- State machine, BUSY:
  - inReady=0.
  - Each cycle performs one iteration and decrements the counter.
  - Multiply: shift-add on a 2*XLEN product register.
  - Divide: restoring step on the remainder/quotient pair.
  - When the counter reaches 1, apply sign correction, select the output, register mdOut, set outValid=1 and go to DONE.
- State machine, DONE:
  - mdOut and outValid are held stable until outReady=1.
  - On outValid&&outReady: outValid=0, go to IDLE.
  - inReady=0 in DONE, so back-to-back operations incur one IDLE cycle.
- Latency:
  - Handshake at cycle 0; outValid rises in cycle XLEN+1.
  - Throughput is one operation per XLEN+2 cycles with outReady held high.
- Signedness:
  - MULH/DIV/REM treat both operands as signed.
  - MULHSU treats opA as signed and opB as unsigned.
  - The others treat both operands as unsigned.
  - The core operates on magnitudes; the sign is reapplied by two's complement negation.
  - REM takes the sign of the dividend.
- Result selection:
  - MUL returns product[XLEN-1:0].
  - MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
  - Arithmetic wraps modulo 2^XLEN.
- Divide by zero (opB=0):
  - Quotient = all ones (DIV and DIVU).
  - Remainder = opA.
  - No exception is raised.
- Signed overflow (DIV/REM with opA=-2^(XLEN-1), opB=-1):
  - Quotient = opA.
  - Remainder = 0.
- Flush:
  - flush=1 at any edge with rst_n high forces IDLE and outValid=0; the in-flight result is discarded.
  - flush has priority over a simultaneous input handshake: that operation is dropped and inReady is effectively ignored for that cycle.
- Reset mid-operation: same as flush, plus mdOut=0.
- Unknown mdOp is impossible (3-bit full decode).

Optional Feature:
- Macro: ALU_MULDIV_EARLY_OUT_EN.
- Defined:
  - Divide-by-zero, signed overflow, and any operation with opA=0 or opB=0 bypass BUSY.
  - The result is registered in the cycle after the handshake: IDLE->DONE, outValid in cycle 1.
- Undefined:
  - These cases run the full XLEN iterations.
  - They produce identical values with normal latency.

Test Plan:
- XLEN=32, MUL opA=7 opB=4, outReady=1 -> outValid first high in cycle 33, mdOut=0x0000001C; inReady low cycles 1-33.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000. MULHU on the same operands -> 0xFFFFFFFE. MULHSU on the same operands -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
  - With ALU_MULDIV_EARLY_OUT_EN defined: each outValid arrives in cycle 1.
  - With the macro undefined: each outValid arrives in cycle 33.
- Backpressure: hold outReady=0 for 10 cycles after outValid -> mdOut stable, inReady=0, busy=1; raise outReady -> IDLE next cycle, inReady=1.
- Flush at cycle 10 of a DIV, and separately rst_n=0 at cycle 10 of a MUL -> IDLE next edge, outValid never asserted. A following MUL 3*5 returns 15.
